// File: rtl/parallel_to_serial.sv
// parallel_to_serial: framed, oversampled serial transmitter.
// Sends 1 start bit (0), DATA_WIDTH data bits LSB first, 1 stop bit (1).
// Each bit lasts SAMPLES_PER_BIT sample ticks; a tick occurs every
// CLKS_PER_SAMPLE clocks. SAMPLES_PER_BIT must be 2..16, CLKS_PER_SAMPLE >= 1.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   in     : parallel word, captured when a load is accepted in IDLE
//   load   : send request, ignored while busy
//   data   : serial line, idles high
//   sample : sample phase within current bit, 0 in IDLE
//   busy   : high while a frame is in progress
//   done   : one-cycle pulse after the final stop-bit clock
module parallel_to_serial #(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned SAMPLES_PER_BIT = 16,
   parameter int unsigned CLKS_PER_SAMPLE = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  load,
   output logic                  data,
   output logic [3:0]            sample,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned DIV_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
   localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_SAMPLE - 1);
   localparam logic [3:0]       SMP_LAST = 4'(SAMPLES_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [3:0]            sample_q, sample_d;
   logic                  data_q, data_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  tick_c;
   logic                  bit_end_c;

   // Sample tick on divider wrap; the divider never runs in IDLE.
   assign tick_c    = (state_q != S_IDLE) && (div_q == DIV_LAST);
   // Last clock of the current serial bit.
   assign bit_end_c = tick_c && (sample_q == SMP_LAST);

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         idx_q    <= '0;
         div_q    <= '0;
         sample_q <= '0;
         data_q   <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
         div_q    <= div_d;
         sample_q <= sample_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      div_d    = div_q;
      sample_d = sample_q;
      data_d   = data_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      if (state_q != S_IDLE) begin
         div_d = tick_c ? '0 : div_q + DIV_W'(1);
         if (tick_c) begin
            sample_d = bit_end_c ? 4'd0 : sample_q + 4'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            div_d    = '0;
            sample_d = 4'd0;
            data_d   = 1'b1;
            busy_d   = 1'b0;
            if (load) begin
               state_d = S_START;
               shift_d = in;
               idx_d   = '0;
               data_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_START: begin
            if (bit_end_c) begin
               state_d = S_DATA;
               idx_d   = '0;
               data_d  = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end_c) begin
               if (idx_q == IDX_LAST) begin
                  state_d = S_STOP;
                  data_d  = 1'b1;
               end else begin
                  // Next data bit is presented from the already-shifted word.
                  shift_d = shift_q >> 1;
                  idx_d   = idx_q + IDX_W'(1);
                  data_d  = shift_d[0];
               end
            end
         end
         S_STOP: begin
            if (bit_end_c) begin
               state_d = S_IDLE;
               data_d  = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign data   = data_q;
   assign sample = sample_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Testbench for parallel_to_serial: default instance checked cycle by cycle
// against expected frames, plus a CLKS_PER_SAMPLE=4 instance decoded by a
// mid-bit (phase 7) loopback receiver model.
module tb_parallel_to_serial;

   typedef struct {
      logic [7:0] word;
      logic [9:0] frame;   // {stop, data[7:0], start} as seen on the line
   } vec_t;

   vec_t tbl[8];

   logic       clk;
   logic       clk_en;
   logic       reset;
   logic [7:0] in0, in1;
   logic       load0, load1;
   logic       data0, data1;
   logic [3:0] sample0, sample1;
   logic       busy0, busy1;
   logic       done0, done1;

   int n_checks = 0;
   int n_fail   = 0;
   int n_unexp  = 0;

   logic [9:0] q0[$];
   logic [9:0] q1[$];

   parallel_to_serial dut0 (
      .clk(clk), .reset(reset), .in(in0), .load(load0),
      .data(data0), .sample(sample0), .busy(busy0), .done(done0)
   );

   parallel_to_serial #(.DATA_WIDTH(8), .SAMPLES_PER_BIT(16), .CLKS_PER_SAMPLE(4)) dut1 (
      .clk(clk), .reset(reset), .in(in1), .load(load1),
      .data(data1), .sample(sample1), .busy(busy1), .done(done1)
   );

   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Default-instance monitor: every frame cycle compared to the expected frame.
   bit         m_in = 1'b0;
   int         m_c, m_err;
   logic [9:0] m_exp;
   logic [7:0] m_rx;

   always @(posedge reset) m_in = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         if (m_in && m_c > 160) begin
            check("done_pulse", done0, 1);
            check("busy_fall", busy0, 0);
            check("gap_data", data0, 1);
            check("gap_sample", sample0, 0);
            check("frame_cycle_errs", m_err, 0);
            check("rx_word", m_rx, m_exp[8:1]);
            m_in = 1'b0;
         end
         if (!m_in && busy0) begin
            if (q0.size() == 0) begin
               n_unexp++;
               m_exp = 10'h3FF;
            end else begin
               m_exp = q0.pop_front();
            end
            m_in  = 1'b1;
            m_c   = 1;
            m_err = 0;
            m_rx  = '0;
         end
         if (m_in) begin
            int bi, ph;
            bi = (m_c - 1) / 16;
            ph = (m_c - 1) % 16;
            if (data0 !== m_exp[bi] || sample0 !== 4'(ph) || busy0 !== 1'b1 || done0 !== 1'b0)
               m_err++;
            if (ph == 7 && bi >= 1 && bi <= 8) m_rx[bi-1] = data0;
            m_c++;
         end
      end
   end

   // Loopback receiver model for the slow instance: samples at phase 7.
   bit         r1_active = 1'b0;
   int         r1_cnt, r1_len;
   logic [9:0] r1_bits, r1_exp;
   logic [3:0] r1_prev = 4'd0;

   always @(posedge reset) r1_active = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         if (busy1) begin
            if (!r1_active) begin
               r1_active = 1'b1;
               r1_cnt    = 0;
               r1_len    = 0;
               r1_bits   = '0;
               if (q1.size() == 0) begin
                  n_unexp++;
                  r1_exp = 10'h3FF;
               end else begin
                  r1_exp = q1.pop_front();
               end
            end
            r1_len++;
            if (sample1 == 4'd7 && r1_prev != 4'd7 && r1_cnt < 10) begin
               r1_bits[r1_cnt] = data1;
               r1_cnt++;
            end
         end else if (r1_active) begin
            r1_active = 1'b0;
            check("lb_done", done1, 1);
            check("lb_len", r1_len, 640);
            check("lb_nbits", r1_cnt, 10);
            check("lb_frame", r1_bits, r1_exp);
            check("lb_word", r1_bits[8:1], r1_exp[8:1]);
         end
         r1_prev = sample1;
      end
   end

   task automatic send0(input int idx);
      @(negedge clk);
      in0   = tbl[idx].word;
      load0 = 1'b1;
      q0.push_back(tbl[idx].frame);
      @(negedge clk);
      load0 = 1'b0;
      check("start_latency_data", data0, 0);
      check("start_latency_busy", busy0, 1);
   endtask

   task automatic wait_done0(input int budget);
      int n = 0;
      while (done0 !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done0_seen", done0, 1);
   endtask

   task automatic send1(input int idx);
      int n = 0;
      @(negedge clk);
      in1   = tbl[idx].word;
      load1 = 1'b1;
      q1.push_back(tbl[idx].frame);
      @(negedge clk);
      load1 = 1'b0;
      while (done1 !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("done1_seen", done1, 1);
   endtask

   initial begin
      tbl[0] = '{8'hA5, 10'b1_1010_0101_0};
      tbl[1] = '{8'h00, 10'b1_0000_0000_0};
      tbl[2] = '{8'hFF, 10'b1_1111_1111_0};
      tbl[3] = '{8'h5A, 10'b1_0101_1010_0};
      tbl[4] = '{8'h3C, 10'b1_0011_1100_0};
      tbl[5] = '{8'hC3, 10'b1_1100_0011_0};
      tbl[6] = '{8'h81, 10'b1_1000_0001_0};
      tbl[7] = '{8'h96, 10'b1_1001_0110_0};

      clk_en = 1'b0;
      reset  = 1'b0;
      load0  = 1'b0;
      load1  = 1'b0;
      in0    = '0;
      in1    = '0;

      // Reset with the clock stopped.
      #1 reset = 1'b1;
      #1;
      check("rst_data", data0, 1);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_sample", sample0, 0);
      check("rst_data1", data1, 1);
      check("rst_busy1", busy1, 0);
      #5 reset = 1'b0;
      clk_en = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_data", data0, 1);

      // Single frames from the table.
      for (int i = 0; i < 3; i++) begin
         send0(i);
         wait_done0(400);
         repeat (4) @(negedge clk);
      end

      // Mid-frame load and input change are ignored.
      send0(3);
      repeat (49) @(negedge clk);
      in0   = 8'hFF;
      load0 = 1'b1;
      @(negedge clk);
      load0 = 1'b0;
      in0   = 8'h00;
      wait_done0(400);
      repeat (200) @(negedge clk);
      check("no_second_frame", busy0, 0);

      // load held high: back-to-back frames with one idle clock between.
      @(negedge clk);
      in0   = tbl[4].word;
      load0 = 1'b1;
      q0.push_back(tbl[4].frame);
      q0.push_back(tbl[4].frame);
      wait_done0(400);
      check("b2b_gap_data", data0, 1);
      check("b2b_gap_sample", sample0, 0);
      @(negedge clk);
      check("b2b_restart", busy0, 1);
      check("b2b_start_bit", data0, 0);
      wait_done0(400);
      load0 = 1'b0;
      repeat (5) @(negedge clk);
      check("b2b_stopped", busy0, 0);

      // Asynchronous reset at clock 70 of a frame, with the clock stopped.
      send0(5);
      repeat (69) @(negedge clk);
      check("pre_reset_busy", busy0, 1);
      clk_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("midrst_data", data0, 1);
      check("midrst_busy", busy0, 0);
      check("midrst_sample", sample0, 0);
      check("midrst_done", done0, 0);
      #2 reset = 1'b0;
      clk_en = 1'b1;
      repeat (20) @(negedge clk);
      check("post_reset_idle", busy0, 0);
      send0(6);
      wait_done0(400);
      repeat (4) @(negedge clk);

      // Slow instance with loopback receiver.
      send1(1);
      send1(2);
      send1(7);
      repeat (10) @(negedge clk);

      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      check("unexpected_frames", n_unexp, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
- Serial transmitter for the battleship link. Takes an 8-bit game word and shifts it out on a single line as a framed, oversampled bit stream.
- Sits directly upstream of the serial receiver (serial_to_parallel), which samples each bit at mid-bit phase 7 of a 16-phase sample count.
- Also drives the sample phase counter it generates, so a local loopback receiver can share it.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- SAMPLES_PER_BIT, 16, sample ticks per serial bit; legal range 2..16, because the sample port is 4 bits.
- CLKS_PER_SAMPLE, 1, clk cycles per sample tick; legal range 1 or more.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  DATA_WIDTH  parallel word to send; captured on an accepted load.
- load  input  1  request to send in; accepted only in IDLE.
- data  output  1  serial line; idles high.
- sample  output  4  current sample phase within the bit, 0..SAMPLES_PER_BIT-1.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (async, any time, including mid-frame):
  - data=1, sample=0, busy=0, done=0.
  - State IDLE, shift register and all counters cleared.
  - A partial frame is abandoned; nothing resumes after reset.
- Frame format:
  - 1 start bit (0), then DATA_WIDTH data bits LSB first, then 1 stop bit (1).
  - Every bit lasts SAMPLES_PER_BIT*CLKS_PER_SAMPLE clocks.
  - Default frame length is 10*16*1 = 160 clocks.
- Tick generation:
  - The divider counts 0..CLKS_PER_SAMPLE-1 and produces a tick on the wrap.
  - The divider is held at 0 in IDLE.
  - sample increments on each tick, wraps from SAMPLES_PER_BIT-1 to 0, and the bit index advances on that wrap.
- States:
  - IDLE: data=1, busy=0, sample=0. If load=1 at an edge, latch in, go to START, busy=1 and data=0 from that edge. Latency load-to-start-edge is 1 clock.
  - START: hold data=0 for one bit period, then go to DATA with bit index 0.
  - DATA: data = shift[0]. At each bit wrap, shift right and increment the index. After bit DATA_WIDTH-1 completes, go to STOP.
  - STOP: data=1 for one bit period. On the final clock of the stop bit, go to IDLE and assert done=1 for exactly that following cycle; busy=0 in the same cycle.
- load handling:
  - load while busy is ignored and not queued; in changing mid-frame has no effect.
  - load held continuously starts the next frame on the first IDLE cycle. This gives exactly 1 idle-high clock between back-to-back frames.
  - load asserted in the done cycle is accepted, because the state is already IDLE.
- All outputs are registered and glitch-free.
- sample is 0 throughout IDLE.

Test Plan:
- Reset → data=1, busy=0, done=0, sample=0. Assert reset while clk is stopped and confirm the outputs change without a clock edge.
- load=1 for 1 clk with in=8'hA5 (defaults):
  - data=0 for clocks 1-16, then bits 1,0,1,0,0,1,0,1 for 16 clocks each, then 1 for 16 clocks.
  - done pulses at clock 161, busy falls at the same time.
  - sample repeatedly counts 0..15 during the frame.
- Load in=8'h5A, then pulse load with in=8'hFF at clock 50 → the transmitted frame is still 8'h5A and no second frame follows.
- load held high with in=8'h3C → two consecutive 8'h3C frames separated by exactly 1 clock of data=1 and sample=0.
- Reset asserted at clock 70 of a 8'hC3 frame:
  - data=1 and busy=0 immediately.
  - A later load of 8'h81 sends a clean, complete frame.
- CLKS_PER_SAMPLE=4, loopback into serial_to_parallel using the sample output, for in=8'h00, 8'hFF and 8'h96 → bit period is 64 clocks and the receiver out matches each word after its stop bit.
